// File: rtl/decode_general_reg_if.sv
// Signal bundle for the general-register select decoder: decode request fields in,
// 24 one-hot register selects out.
interface decode_general_reg_if;
  logic [1:0] bit_width;
  logic [2:0] register_sequence_code;
  logic       w_in_instruction;
  logic       w;

  logic AL,  CL,  DL,  BL,  AH,  CH,  DH,  BH;
  logic EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI;
  logic AX,  CX,  DX,  BX,  SP,  BP,  SI,  DI;

  modport master (
    output bit_width, register_sequence_code, w_in_instruction, w,
    input  AL,  CL,  DL,  BL,  AH,  CH,  DH,  BH,
    input  EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI,
    input  AX,  CX,  DX,  BX,  SP,  BP,  SI,  DI
  );

  modport slave (
    input  bit_width, register_sequence_code, w_in_instruction, w,
    output AL,  CL,  DL,  BL,  AH,  CH,  DH,  BH,
    output EAX, ECX, EDX, EBX, ESP, EBP, ESI, EDI,
    output AX,  CX,  DX,  BX,  SP,  BP,  SI,  DI
  );
endinterface

// File: rtl/decode_general_reg.sv
// Registered x86 general-register select decoder: reg/rm field plus w bit and operand
// size produce one of 24 one-hot selects (8/16/32-bit names), one cycle later.
module decode_general_reg (
  input logic                  clk,
  input logic                  reset,
  decode_general_reg_if.slave  bus
);

  typedef enum logic [1:0] {Width8, Width16, Width32, WidthNone} width_e;

  width_e      width_d;
  logic [7:0]  code_onehot;
  // Select vector layout: [7:0] 8-bit, [15:8] 32-bit, [23:16] 16-bit, each in code order.
  logic [23:0] sel_d;
  logic [23:0] sel_q;

  always_comb begin
    width_d = WidthNone;
    if (bus.w_in_instruction && !bus.w) begin
      width_d = Width8;
    end else begin
      unique case (bus.bit_width)
        2'b01:   width_d = Width32;
        2'b10:   width_d = Width16;
        default: width_d = WidthNone;
      endcase
    end
  end

  always_comb begin
    code_onehot = '0;
    code_onehot[bus.register_sequence_code] = 1'b1;
  end

  always_comb begin
    sel_d = '0;
    unique case (width_d)
      Width8:    sel_d[7:0]   = code_onehot;
      Width32:   sel_d[15:8]  = code_onehot;
      Width16:   sel_d[23:16] = code_onehot;
      default:   sel_d        = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign {bus.BH, bus.DH, bus.CH, bus.AH, bus.BL, bus.DL, bus.CL, bus.AL} = sel_q[7:0];
  assign {bus.EDI, bus.ESI, bus.EBP, bus.ESP,
          bus.EBX, bus.EDX, bus.ECX, bus.EAX} = sel_q[15:8];
  assign {bus.DI, bus.SI, bus.BP, bus.SP, bus.BX, bus.DX, bus.CX, bus.AX} = sel_q[23:16];

endmodule

// File: tb/tb_decode_general_reg.sv
// Self-checking bench for decode_general_reg: expected selects are queued as each
// decode is driven and popped when the registered outputs become valid.
module tb_decode_general_reg;

  logic clk;
  logic reset;

  decode_general_reg_if bus ();

  decode_general_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [23:0] observed,
                          input logic [23:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%06h expected=%06h", tag, observed, expected);
    end
  endtask

  // Reference model: index = group base + code; 8-bit base 0, 32-bit base 8, 16-bit base 16.
  function automatic logic [23:0] model(input logic rst, input logic [1:0] bw,
                                        input logic [2:0] code, input logic wi,
                                        input logic wv);
    logic [23:0] r;
    int base;
    r = '0;
    if (rst) return r;
    if (wi && !wv)        base = 0;
    else if (bw == 2'b01) base = 8;
    else if (bw == 2'b10) base = 16;
    else return r;
    r[base + int'(code)] = 1'b1;
    return r;
  endfunction

  function automatic logic [23:0] observe();
    return {bus.DI,  bus.SI,  bus.BP,  bus.SP,  bus.BX,  bus.DX,  bus.CX,  bus.AX,
            bus.EDI, bus.ESI, bus.EBP, bus.ESP, bus.EBX, bus.EDX, bus.ECX, bus.EAX,
            bus.BH,  bus.DH,  bus.CH,  bus.AH,  bus.BL,  bus.DL,  bus.CL,  bus.AL};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [1:0] bw,
                      input logic [2:0] code, input logic wi, input logic wv);
    logic [23:0] obs;
    logic [23:0] e;
    reset                      = rst;
    bus.bit_width              = bw;
    bus.register_sequence_code = code;
    bus.w_in_instruction       = wi;
    bus.w                      = wv;
    exp_q.push_back(model(rst, bw, code, wi, wv));
    @(posedge clk);
    #1;
    obs = observe();
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
      check_eq({tag, "_onehot"}, 24'($countones(obs) <= 1), 24'd1);
    end
  endtask

  initial begin
    // Reset held two cycles with an EAX-decoding input present.
    step("reset0", 1'b1, 2'b01, 3'd0, 1'b1, 1'b1);
    step("reset1", 1'b1, 2'b01, 3'd0, 1'b1, 1'b1);
    check_eq("reset_fixed", observe(), 24'h0);
    step("post_reset_eax", 1'b0, 2'b01, 3'd0, 1'b1, 1'b1);
    check_eq("eax_fixed", observe(), 24'h000100);

    for (int c = 0; c < 8; c++) step("sweep8", 1'b0, 2'b01, 3'(c), 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) step("sweep32_w", 1'b0, 2'b01, 3'(c), 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step("sweep32_now", 1'b0, 2'b01, 3'(c), 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) step("sweep16", 1'b0, 2'b10, 3'(c), 1'b0, 1'b1);

    step("sp16", 1'b0, 2'b10, 3'd4, 1'b0, 1'b0);
    check_eq("sp_fixed", observe(), 24'h100000);
    step("di16", 1'b0, 2'b10, 3'd7, 1'b0, 1'b0);
    check_eq("di_fixed", observe(), 24'h800000);
    step("ah8", 1'b0, 2'b10, 3'd4, 1'b1, 1'b0);
    check_eq("ah_fixed", observe(), 24'h000010);

    step("invalid_w1", 1'b0, 2'b00, 3'd2, 1'b1, 1'b1);
    check_eq("invalid_fixed", observe(), 24'h0);
    step("invalid_dl", 1'b0, 2'b00, 3'd2, 1'b1, 1'b0);
    check_eq("dl_fixed", observe(), 24'h000004);

    // Mid-stream reset must drop the in-flight decode.
    step("pre_midreset", 1'b0, 2'b01, 3'd5, 1'b0, 1'b0);
    step("midreset", 1'b1, 2'b10, 3'd6, 1'b0, 1'b0);
    step("post_midreset", 1'b0, 2'b10, 3'd6, 1'b0, 1'b0);

    for (int bw = 0; bw < 4; bw++) begin
      for (int i = 0; i < 32; i++) begin
        step("exhaustive", 1'b0, 2'(bw), i[2:0], i[4], i[3]);
      end
    end

    // Random back-to-back decodes with occasional reset.
    for (int n = 0; n < 200; n++) begin
      step("random", ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
